encode_mul_arb: RTL and testbench

ENCODE_MUL_ARB -- requirements
Module: encode_mul_arb

---
 rtl/encode_mul_pkg.sv | 16 +
 rtl/encode_mul_pipe.sv | 47 ++++
 rtl/encode_mul_arb.sv | 137 +++++++++++++
 tb/tb_encode_mul_arb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encode_mul_pkg.sv
// rtl/encode_mul_pkg.sv - shared widths and tag sizing for the arbitrated signed multiplier
package encode_mul_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int A_WIDTH_DEF = 40;
   localparam int B_WIDTH_DEF = 23;
   localparam int P_WIDTH_DEF = 62;

   // A single requester still needs a one-bit tag so the port is never zero-width.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int TAG_WIDTH_DEF = tag_width(NUM_REQ_DEF);

endpackage

// File: rtl/encode_mul_pipe.sv
// rtl/encode_mul_pipe.sv - registered signed multiplier stage with clock-enable (pipeline stage S1)
module encode_mul_pipe
   import encode_mul_pkg::*;
#(
   parameter int A_WIDTH = A_WIDTH_DEF,
   parameter int B_WIDTH = B_WIDTH_DEF,
   parameter int P_WIDTH = P_WIDTH_DEF,
   parameter int TAG_W   = TAG_WIDTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ce_i,
   input  logic                      valid_i,
   input  logic [TAG_W-1:0]          tag_i,
   input  logic signed [A_WIDTH-1:0] a_i,
   input  logic signed [B_WIDTH-1:0] b_i,
   output logic                      valid_o,
   output logic [TAG_W-1:0]          tag_o,
   output logic signed [P_WIDTH-1:0] p_o
);

   logic                      valid_q;
   logic [TAG_W-1:0]          tag_q;
   logic signed [P_WIDTH-1:0] prod_d;
   logic signed [P_WIDTH-1:0] prod_q;

   // Operands are sign-extended to the product width first, so the multiply is
   // exact whenever the result fits and keeps the low P_WIDTH bits otherwise.
   assign prod_d = P_WIDTH'(a_i) * P_WIDTH'(b_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         prod_q  <= '0;
      end else if (ce_i) begin
         valid_q <= valid_i;
         tag_q   <= tag_i;
         prod_q  <= prod_d;
      end
   end

   assign valid_o = valid_q;
   assign tag_o   = tag_q;
   assign p_o     = prod_q;

endmodule

// File: rtl/encode_mul_arb.sv
// rtl/encode_mul_arb.sv - round-robin arbiter feeding one shared two-stage signed multiplier
module encode_mul_arb
   import encode_mul_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int A_WIDTH = A_WIDTH_DEF,
   parameter int B_WIDTH = B_WIDTH_DEF,
   parameter int P_WIDTH = P_WIDTH_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*A_WIDTH-1:0]     req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0]     req_b,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           res_valid,
   output logic [P_WIDTH-1:0]             res_data,
   output logic [tag_width(NUM_REQ)-1:0]  res_tag,
   input  logic                           res_ready,
   output logic                           busy
);

   localparam int               TAG_W    = tag_width(NUM_REQ);
   localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_REQ - 1);

   logic [TAG_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic                      s0_valid_q, s0_valid_d;
   logic [TAG_W-1:0]          s0_tag_q, s0_tag_d;
   logic signed [A_WIDTH-1:0] s0_a_q, s0_a_d;
   logic signed [B_WIDTH-1:0] s0_b_q, s0_b_d;

   logic                      adv;
   logic                      accept_en;
   logic                      grant_found;
   logic [TAG_W-1:0]          grant_idx;
   logic                      xfer;
   logic [A_WIDTH-1:0]        sel_a;
   logic [B_WIDTH-1:0]        sel_b;

   logic                      s1_valid;
   logic [TAG_W-1:0]          s1_tag;
   logic signed [P_WIDTH-1:0] s1_prod;

   assign adv       = ~(s1_valid & ~res_ready);
   assign accept_en = adv & reset;

   // First pass covers rr_ptr..NUM_REQ-1, second pass wraps to 0..rr_ptr-1.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[i] && (TAG_W'(i) >= rr_ptr_q)) begin
            grant_found = 1'b1;
            grant_idx   = TAG_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = TAG_W'(i);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == TAG_W'(i)) begin
            sel_a        = req_a[i*A_WIDTH +: A_WIDTH];
            sel_b        = req_b[i*B_WIDTH +: B_WIDTH];
            req_ready[i] = accept_en & grant_found;
         end
      end
   end

   assign xfer = accept_en & grant_found;

   // With no grant S0 takes a bubble; nothing moves at all while stalled.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      s0_valid_d = s0_valid_q;
      s0_tag_d   = s0_tag_q;
      s0_a_d     = s0_a_q;
      s0_b_d     = s0_b_q;
      if (adv) begin
         s0_valid_d = grant_found;
         s0_tag_d   = grant_idx;
         s0_a_d     = sel_a;
         s0_b_d     = sel_b;
      end
      if (xfer) begin
         rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q   <= '0;
         s0_valid_q <= 1'b0;
         s0_tag_q   <= '0;
         s0_a_q     <= '0;
         s0_b_q     <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         s0_valid_q <= s0_valid_d;
         s0_tag_q   <= s0_tag_d;
         s0_a_q     <= s0_a_d;
         s0_b_q     <= s0_b_d;
      end
   end

   encode_mul_pipe #(
      .A_WIDTH (A_WIDTH),
      .B_WIDTH (B_WIDTH),
      .P_WIDTH (P_WIDTH),
      .TAG_W   (TAG_W)
   ) u_s1 (
      .clk     (clk),
      .rst_n   (reset),
      .ce_i    (adv),
      .valid_i (s0_valid_q),
      .tag_i   (s0_tag_q),
      .a_i     (s0_a_q),
      .b_i     (s0_b_q),
      .valid_o (s1_valid),
      .tag_o   (s1_tag),
      .p_o     (s1_prod)
   );

   assign res_valid = s1_valid;
   assign res_data  = s1_prod;
   assign res_tag   = s1_tag;
   assign busy      = s0_valid_q | s1_valid;

endmodule

// File: tb/tb_encode_mul_arb.sv
// tb/tb_encode_mul_arb.sv - scoreboard bench for the arbitrated signed multiplier
module tb_encode_mul_arb;

   localparam int N  = 4;
   localparam int AW = 40;
   localparam int BW = 23;
   localparam int PW = 62;
   localparam int TW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_a;
   logic [N*BW-1:0] req_b;
   logic [N-1:0]    req_ready;
   logic            res_valid;
   logic [PW-1:0]   res_data;
   logic [TW-1:0]   res_tag;
   logic            res_ready;
   logic            busy;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [PW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   encode_mul_arb #(
      .NUM_REQ (N),
      .A_WIDTH (AW),
      .B_WIDTH (BW),
      .P_WIDTH (PW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_tag   (res_tag),
      .res_ready (res_ready),
      .busy      (busy)
   );

   function automatic logic [PW-1:0] model_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
      longint sa;
      longint sbv;
      longint p;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      p   = sa * sbv;
      return p[PW-1:0];
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset === 1'b1) begin
         n_checks++;
         if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != '0)) begin
            n_fail++;
            $display("FAIL ready_onehot req_ready=%b req_valid=%b", req_ready, req_valid);
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.tag  = TW'(i);
               e.data = model_mul(req_a[i*AW +: AW], req_b[i*BW +: BW]);
               sb.push_back(e);
            end
         end
         if (res_valid && res_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_result tag=%0d data=%h", res_tag, res_data);
            end else begin
               e = sb.pop_front();
               if (res_tag !== e.tag || res_data !== e.data) begin
                  n_fail++;
                  $display("FAIL scoreboard got tag=%0d data=%h expected tag=%0d data=%h",
                           res_tag, res_data, e.tag, e.data);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
      req_a[i*AW +: AW] = a;
      req_b[i*BW +: BW] = b;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         set_req(i, AW'({$urandom(), $urandom()}), BW'($urandom()));
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      sb.delete();
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic drain(input string name);
      req_valid = '0;
      res_ready = 1'b1;
      for (int k = 0; k < 20 && (sb.size() != 0 || busy !== 1'b0); k++) tick();
      n_checks++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_%s pending=%0d busy=%b required pending=0 busy=0", name, sb.size(), busy);
      end
      sb.delete();
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      req_valid = '1;
      res_ready = 1'b1;
      rand_ops();
      tick();
      tick();
      @(negedge clk);
      n_checks += 5;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b req=0", res_valid); end
      if (res_data !== '0)    begin n_fail++; $display("FAIL reset_res_data got=%h req=0", res_data); end
      if (res_tag !== '0)     begin n_fail++; $display("FAIL reset_res_tag got=%0d req=0", res_tag); end
      if (req_ready !== '0)   begin n_fail++; $display("FAIL reset_req_ready got=%b req=0000", req_ready); end
      if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b req=0", busy); end
      tick();
      req_valid = 4'b0110;
      reset     = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL first_grant got=%b req=0010", req_ready); end
      tick();
      drain("reset");
   endtask

   task automatic test_single();
      logic [PW-1:0] exp_p;
      exp_p = PW'(-15);
      set_req(0, AW'(3), BW'(-5));
      req_valid = 4'b0001;
      res_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b req=0001", req_ready); end
      tick();
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got=%b req=0", res_valid); end
      tick();
      @(negedge clk);
      n_checks += 3;
      if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b req=1", res_valid); end
      if (res_data !== exp_p) begin n_fail++; $display("FAIL single_data got=%h req=%h", res_data, exp_p); end
      if (res_tag !== 2'd0)   begin n_fail++; $display("FAIL single_tag got=%0d req=0", res_tag); end
      tick();
      drain("single");
   endtask

   task automatic test_extremes();
      logic [PW-1:0] exp_min;
      logic [PW-1:0] exp_max;
      exp_min = 62'h2000_0000_0000_0000;
      exp_max = 62'h1FFF_FF7F_FFC0_0001;
      res_ready = 1'b1;
      set_req(0, 40'h80_0000_0000, 23'h40_0000);
      req_valid = 4'b0001;
      tick();
      set_req(0, 40'h7F_FFFF_FFFF, 23'h3F_FFFF);
      tick();
      req_valid = '0;
      @(negedge clk);
      n_checks += 2;
      if (res_valid !== 1'b1)   begin n_fail++; $display("FAIL ext_min_valid got=%b req=1", res_valid); end
      if (res_data !== exp_min) begin n_fail++; $display("FAIL ext_min_data got=%h req=%h", res_data, exp_min); end
      tick();
      @(negedge clk);
      n_checks += 2;
      if (res_valid !== 1'b1)   begin n_fail++; $display("FAIL ext_max_valid got=%b req=1", res_valid); end
      if (res_data !== exp_max) begin n_fail++; $display("FAIL ext_max_data got=%h req=%h", res_data, exp_max); end
      tick();
      drain("extremes");
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_rdy;
      pulse_reset();
      for (int i = 0; i < N; i++) set_req(i, AW'(i * 1000 + 7), BW'(-(i + 1) * 3));
      req_valid = '1;
      res_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_rdy = N'(1) << (k % N);
         @(negedge clk);
         n_checks++;
         if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL rr_grant_%0d got=%b req=%b", k, req_ready, exp_rdy);
         end
         tick();
      end
      drain("round_robin");
   endtask

   task automatic test_backpressure();
      exp_t head;
      rand_ops();
      req_valid = '1;
      res_ready = 1'b1;
      tick();
      tick();
      res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks += 4;
         if (req_ready !== '0) begin n_fail++; $display("FAIL stall_ready_%0d got=%b req=0000", k, req_ready); end
         if (res_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_%0d got=%b req=1", k, res_valid); end
         if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy_%0d got=%b req=1", k, busy); end
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL stall_sb_%0d scoreboard empty while result held", k);
         end else begin
            head = sb[0];
            if (res_data !== head.data || res_tag !== head.tag) begin
               n_fail++;
               $display("FAIL stall_hold_%0d got tag=%0d data=%h req tag=%0d data=%h",
                        k, res_tag, res_data, head.tag, head.data);
            end
         end
         tick();
         rand_ops();
      end
      res_ready = 1'b1;
      repeat (4) begin
         tick();
         rand_ops();
      end
      drain("backpressure");
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      rand_ops();
      req_valid = '1;
      res_ready = 1'b1;
      tick();
      tick();
      tick();
      reset = 1'b0;
      sb.delete();
      #1;
      n_checks += 3;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b req=0", res_valid); end
      if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy got=%b req=0", busy); end
      if (req_ready !== '0)   begin n_fail++; $display("FAIL midrst_ready got=%b req=0000", req_ready); end
      tick();
      req_valid = 4'b1100;
      tick();
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL midrst_grant got=%b req=0100", req_ready); end
      tick();
      drain("reset_mid");
   endtask

   task automatic test_random();
      for (int c = 0; c < 10000; c++) begin
         req_valid = N'($urandom());
         rand_ops();
         res_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain("random");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b0;
      test_reset();
      test_single();
      test_extremes();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
